// File: rtl/fsm_alu_pkg.sv
// Shared types and constants for the sequenced ALU engine (fsm_alu_seq).
// The optional FSM_ALU_SAT_EN build macro is handled in fsm_alu_step.
package fsm_alu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_ADD,
    ST_SUB,
    ST_SHL,
    ST_OUT_RES,
    ST_OUT_B,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_ADD,
    STEP_SUB,
    STEP_SHL
  } step_e;

  localparam int         OP_ADD    = 0;
  localparam int         OP_SUB    = 1;
  localparam int         OP_SHL    = 2;
  localparam logic [2:0] OP_LEGACY = 3'b111;

  // First enabled step strictly after cur in ADD->SUB->SHL order, else OUT_RES.
  function automatic state_e next_step(input state_e cur, input logic [2:0] op_q);
    state_e nxt;
    logic   add_ok;
    logic   sub_ok;
    logic   shl_ok;
    add_ok = (cur == ST_LOAD_B) && op_q[OP_ADD];
    sub_ok = ((cur == ST_LOAD_B) || (cur == ST_ADD)) && op_q[OP_SUB];
    shl_ok = ((cur == ST_LOAD_B) || (cur == ST_ADD) || (cur == ST_SUB)) && op_q[OP_SHL];
    if (add_ok)      nxt = ST_ADD;
    else if (sub_ok) nxt = ST_SUB;
    else if (shl_ok) nxt = ST_SHL;
    else             nxt = ST_OUT_RES;
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_alu_step.sv
// Combinational single ALU step (ADD / SUB / SHL) for fsm_alu_seq.
// Define FSM_ALU_SAT_EN to make ADD/SUB saturate unsigned instead of wrapping.
module fsm_alu_step
  import fsm_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_AMT = 1
) (
  input  step_e              i_sel,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_a,
  output logic               o_flag
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // The extra MSB of w_sum / w_diff is the carry / borrow respectively.
  always_comb begin
    o_a    = i_a;
    o_flag = 1'b0;
    case (i_sel)
      STEP_ADD: begin
        o_flag = w_sum[WIDTH];
`ifdef FSM_ALU_SAT_EN
        o_a = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
        o_a = w_sum[WIDTH-1:0];
`endif
      end
      STEP_SUB: begin
        o_flag = w_diff[WIDTH];
`ifdef FSM_ALU_SAT_EN
        o_a = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
        o_a = w_diff[WIDTH-1:0];
`endif
      end
      STEP_SHL: o_a = i_a << SHIFT_AMT;
      default:  o_a = i_a;
    endcase
  end

endmodule

// File: rtl/fsm_alu_seq.sv
// Sequenced ALU engine: load A and B, run the op-selected ADD/SUB/SHL steps, emit A then B.
// Build option FSM_ALU_SAT_EN (see fsm_alu_step) selects saturating ADD/SUB.
module fsm_alu_seq
  import fsm_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_AMT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             ovf,
  output logic             done
);

  // state | meaning: IDLE wait start, LOAD_A/B take operand, ADD/SUB/SHL one step, OUT_RES/OUT_B beats, DONE pulse
  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_out_data;
  logic             r_ovf;
  logic             r_done;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;

  state_e           w_state_nxt;
  step_e            w_sel;
  logic [WIDTH-1:0] w_step_a;
  logic             w_step_flag;
  logic [WIDTH-1:0] w_a_nxt;
  logic             w_in_hs;
  logic             w_out_hs;

  assign w_in_hs  = in_valid && r_in_ready;
  assign w_out_hs = out_ready && r_out_valid;

  always_comb begin
    w_sel = STEP_NONE;
    case (r_state)
      ST_ADD:  w_sel = STEP_ADD;
      ST_SUB:  w_sel = STEP_SUB;
      ST_SHL:  w_sel = STEP_SHL;
      default: w_sel = STEP_NONE;
    endcase
  end

  fsm_alu_step #(
    .WIDTH     (WIDTH),
    .SHIFT_AMT (SHIFT_AMT)
  ) u_step (
    .i_sel  (w_sel),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_a    (w_step_a),
    .o_flag (w_step_flag)
  );

  assign w_a_nxt = (r_state == ST_LOAD_A && w_in_hs) ? in_data : w_step_a;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start)    w_state_nxt = ST_LOAD_A;
      ST_LOAD_A:  if (w_in_hs)  w_state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (w_in_hs)  w_state_nxt = next_step(ST_LOAD_B, r_op);
      ST_ADD,
      ST_SUB,
      ST_SHL:                   w_state_nxt = next_step(r_state, r_op);
      ST_OUT_RES: if (w_out_hs) w_state_nxt = ST_OUT_B;
      ST_OUT_B:   if (w_out_hs) w_state_nxt = ST_DONE;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      if (r_state == ST_LOAD_B && w_in_hs) r_b <= in_data;
      if (r_state == ST_IDLE && start) begin
        r_op  <= op;
        r_ovf <= 1'b0;
      end else if (w_sel != STEP_NONE) begin
        r_ovf <= r_ovf | w_step_flag;
      end
      case (w_state_nxt)
        ST_OUT_RES: r_out_data <= w_a_nxt;
        ST_OUT_B:   r_out_data <= r_b;
        default:    r_out_data <= r_out_data;
      endcase
      r_in_ready  <= (w_state_nxt == ST_LOAD_A) || (w_state_nxt == ST_LOAD_B);
      r_out_valid <= (w_state_nxt == ST_OUT_RES) || (w_state_nxt == ST_OUT_B);
      r_out_last  <= (w_state_nxt == ST_OUT_B);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign ovf       = r_ovf;
  assign done      = r_done;

endmodule

// File: tb/tb_fsm_alu_seq.sv
// Scoreboard bench for fsm_alu_seq: directed cases plus randomized sequences vs. an arithmetic model.
module tb_fsm_alu_seq;
  import fsm_alu_pkg::*;

  localparam int W = 8;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         ovf;
  logic         done;

  fsm_alu_seq #(.WIDTH(W), .SHIFT_AMT(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         ovf;
  } beat_t;

  beat_t sb[$];
  beat_t mb;
  bit    expect_done = 1'b0;
  int    stall_req   = 0;
  bit    force_low   = 1'b0;
  bit    rnd_ready   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply enabled steps in ADD, SUB, SHL order using integer arithmetic.
  function automatic void model(input logic [2:0] o, input int a, input int b,
                                output int ra, output bit rovf);
    int m;
    m    = 1 << W;
    ra   = a;
    rovf = 1'b0;
    if (o[0]) begin
      ra = ra + b;
      if (ra >= m) begin
        rovf = 1'b1;
`ifdef FSM_ALU_SAT_EN
        ra = m - 1;
`else
        ra = ra - m;
`endif
      end
    end
    if (o[1]) begin
      if (ra < b) begin
        rovf = 1'b1;
`ifdef FSM_ALU_SAT_EN
        ra = 0;
`else
        ra = ra - b + m;
`endif
      end else begin
        ra = ra - b;
      end
    end
    if (o[2]) ra = (ra * (1 << S)) % m;
  endfunction

  // Monitor: consume beats at accepted handshakes, check hold under backpressure and done.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, required no beat", out_data, out_last);
          end else begin
            mb = sb.pop_front();
            chk("beat_data", out_data, mb.data);
            chk("beat_last", out_last, mb.last);
            if (mb.last) begin
              chk("ovf", ovf, mb.ovf);
              expect_done = 1'b1;
            end
          end
        end else if (sb.size() != 0) begin
          chk("hold_data", out_data, sb[0].data);
        end
      end
      if (done) begin
        chk("done_after_last", expect_done, 1);
        expect_done = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (force_low) out_ready = 1'b0;
    else if (stall_req > 0 && out_valid && !out_last) begin
      out_ready = 1'b0;
      stall_req--;
    end else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [W-1:0] v, input int gap);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("load_hold_ready", in_ready, 1);
      chk("load_hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge with the DUT idle.
  task automatic run_seq(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap_b, input int stall, input bit poke, input bit chk_lat);
    int ea;
    bit eo;
    int c0;
    int lat;
    bit got;
    model(o, int'(a), int'(b), ea, eo);
    sb.push_back('{data: W'(ea), last: 1'b0, ovf: eo});
    sb.push_back('{data: b, last: 1'b1, ovf: eo});
    stall_req = stall;
    start = 1'b1;
    op    = o;
    c0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'($urandom);
    send(a, 0);
    send(b, gap_b);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1;
      op    = 3'b000;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc - c0;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (chk_lat) chk("latency", lat, 8 - (3 - $countones(o)));
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea;
    bit eo;
    bit got;
    rst = 1'b1; start = 1'b0; op = 3'b000; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_seq(OP_LEGACY, 8'h30, 8'h10, 0, 0, 0, 1);
    run_seq(3'b001, 8'hF0, 8'h20, 0, 0, 0, 1);
    run_seq(3'b010, 8'h05, 8'h09, 0, 0, 0, 1);
    run_seq(3'b000, 8'h5A, 8'hA5, 0, 0, 0, 1);
    run_seq(3'b100, 8'hC3, 8'h01, 0, 0, 0, 1);
    run_seq(OP_LEGACY, 8'h30, 8'h10, 2, 3, 0, 0);
    run_seq(OP_LEGACY, 8'h30, 8'h10, 0, 0, 1, 1);

    // Reset while a result beat is stalled in OUT_RES.
    force_low = 1'b1;
    model(3'b001, 'hF0, 'h20, ea, eo);
    start = 1'b1; op = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    send(8'hF0, 0);
    send(8'h20, 0);
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("pre_rst_valid", got, 1);
    chk("pre_rst_data", out_data, W'(ea));
    chk("pre_rst_ovf", ovf, eo);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    force_low = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_ovf", ovf, 0);
    chk("post_rst_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {done, out_valid, busy}, 0);
    end
    @(posedge clk); #1;
    run_seq(OP_LEGACY, 8'h30, 8'h10, 0, 0, 0, 1);

    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      run_seq(3'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 2), 0, 0, 0);
    end
    rnd_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
